// File: rtl/read_port_arbiter.sv
// Two-requester read-port arbiter: an instruction requester (ir) and a data-read
// requester (dr) share one memory read port, with at most one transaction in flight.
// Optional feature macro: READ_ARB_ROUND_ROBIN_EN selects round-robin arbitration.
// When it is undefined, dr has fixed priority over ir.
module read_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // instruction requester
  input  logic              ir_addr_valid,
  input  logic [ADDR_W-1:0] ir_addr,
  output logic              ir_addr_ready,
  output logic              ir_data_valid,
  output logic [DATA_W-1:0] ir_data,
  input  logic              ir_data_ready,
  // data-read requester
  input  logic              dr_addr_valid,
  input  logic [ADDR_W-1:0] dr_addr,
  output logic              dr_addr_ready,
  output logic              dr_data_valid,
  output logic [DATA_W-1:0] dr_data,
  input  logic              dr_data_ready,
  // shared memory port
  output logic              mem_addr_valid,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_addr_ready,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_data_ready
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e            state_q;
  logic              owner_q;  // 1: dr owns the transaction, 0: ir
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              mem_addr_valid_q;
  logic              mem_data_ready_q;
  logic              ir_data_valid_q;
  logic              dr_data_valid_q;
  logic              grant_dr;
  logic              accept;
  logic              owner_data_ready;

`ifdef READ_ARB_ROUND_ROBIN_EN
  logic              last_grant_q;  // 1: dr was granted last, 0: ir

  // Round-robin pick: on a tie the requester not granted last wins.
  always_comb begin
    grant_dr = dr_addr_valid;
    if (ir_addr_valid && dr_addr_valid) begin
      grant_dr = ~last_grant_q;
    end
  end
`else
  // Fixed priority pick: dr wins whenever it is requesting.
  always_comb begin
    grant_dr = dr_addr_valid;
  end
`endif

  // Address handshakes are only offered in idle, and only to the winner.
  always_comb begin
    ir_addr_ready    = (state_q == StIdle) && ir_addr_valid && !grant_dr;
    dr_addr_ready    = (state_q == StIdle) && dr_addr_valid && grant_dr;
    accept           = ir_addr_ready || dr_addr_ready;
    owner_data_ready = owner_q ? dr_data_ready : ir_data_ready;
  end

  // Transaction FSM; all handshake outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= StIdle;
      owner_q          <= 1'b0;
      addr_q           <= '0;
      data_q           <= '0;
      mem_addr_valid_q <= 1'b0;
      mem_data_ready_q <= 1'b0;
      ir_data_valid_q  <= 1'b0;
      dr_data_valid_q  <= 1'b0;
`ifdef READ_ARB_ROUND_ROBIN_EN
      last_grant_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q           <= grant_dr ? dr_addr : ir_addr;
            owner_q          <= grant_dr;
`ifdef READ_ARB_ROUND_ROBIN_EN
            last_grant_q     <= grant_dr;
`endif
            mem_addr_valid_q <= 1'b1;
            state_q          <= StAddr;
          end
        end
        StAddr: begin
          if (mem_addr_ready) begin
            mem_addr_valid_q <= 1'b0;
            mem_data_ready_q <= 1'b1;
            state_q          <= StData;
          end
        end
        StData: begin
          if (mem_data_valid) begin
            data_q           <= mem_data;
            mem_data_ready_q <= 1'b0;
            ir_data_valid_q  <= ~owner_q;
            dr_data_valid_q  <= owner_q;
            state_q          <= StResp;
          end
        end
        StResp: begin
          if (owner_data_ready) begin
            ir_data_valid_q <= 1'b0;
            dr_data_valid_q <= 1'b0;
            state_q         <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_addr_valid = mem_addr_valid_q;
  assign mem_addr       = addr_q;
  assign mem_data_ready = mem_data_ready_q;
  assign ir_data_valid  = ir_data_valid_q;
  assign dr_data_valid  = dr_data_valid_q;
  // Read data stays visible until the next memory response overwrites it.
  assign ir_data        = data_q;
  assign dr_data        = data_q;

endmodule

// File: tb/tb_read_port_arbiter.sv
// Directed bench for read_port_arbiter; follows READ_ARB_ROUND_ROBIN_EN if defined.
module tb_read_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir_addr_valid, ir_addr_ready, ir_data_valid, ir_data_ready;
  logic [31:0] ir_addr, ir_data;
  logic        dr_addr_valid, dr_addr_ready, dr_data_valid, dr_data_ready;
  logic [31:0] dr_addr, dr_data;
  logic        mem_addr_valid, mem_addr_ready, mem_data_valid, mem_data_ready;
  logic [31:0] mem_addr, mem_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  read_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .ir_addr_valid  (ir_addr_valid),
    .ir_addr        (ir_addr),
    .ir_addr_ready  (ir_addr_ready),
    .ir_data_valid  (ir_data_valid),
    .ir_data        (ir_data),
    .ir_data_ready  (ir_data_ready),
    .dr_addr_valid  (dr_addr_valid),
    .dr_addr        (dr_addr),
    .dr_addr_ready  (dr_addr_ready),
    .dr_data_valid  (dr_data_valid),
    .dr_data        (dr_data),
    .dr_data_ready  (dr_data_ready),
    .mem_addr_valid (mem_addr_valid),
    .mem_addr       (mem_addr),
    .mem_addr_ready (mem_addr_ready),
    .mem_data_valid (mem_data_valid),
    .mem_data       (mem_data),
    .mem_data_ready (mem_data_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One zero-wait transaction starting in idle; requester valids are left to the caller.
  task automatic txn(input bit exp_dr, input logic [31:0] exp_addr, input logic [31:0] rdata);
    mem_data       = rdata;
    mem_addr_ready = 1'b1;
    mem_data_valid = 1'b1;
    #1;
    check("ir_addr_ready", {31'b0, ir_addr_ready}, {31'b0, !exp_dr});
    check("dr_addr_ready", {31'b0, dr_addr_ready}, {31'b0, exp_dr});
    tick();
    check("mem_addr_valid", {31'b0, mem_addr_valid}, 32'd1);
    check("mem_addr", mem_addr, exp_addr);
    tick();
    check("mem_data_ready", {31'b0, mem_data_ready}, 32'd1);
    tick();
    check("owner_data_valid", {31'b0, exp_dr ? dr_data_valid : ir_data_valid}, 32'd1);
    check("other_data_valid", {31'b0, exp_dr ? ir_data_valid : dr_data_valid}, 32'd0);
    check("owner_data", exp_dr ? dr_data : ir_data, rdata);
    ir_data_ready = 1'b1;
    dr_data_ready = 1'b1;
    tick();
    ir_data_ready = 1'b0;
    dr_data_ready = 1'b0;
    check("data_valid_dropped", {31'b0, ir_data_valid | dr_data_valid}, 32'd0);
  endtask

  initial begin
    int  n_dr;
    bit  last_dr;
    bit  exp_dr;
    rst = 1'b0;
    ir_addr_valid = 1'b0; ir_addr = '0; ir_data_ready = 1'b0;
    dr_addr_valid = 1'b0; dr_addr = '0; dr_data_ready = 1'b0;
    mem_addr_ready = 1'b0; mem_data_valid = 1'b0; mem_data = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Reset values
    check("rst_mem_addr_valid", {31'b0, mem_addr_valid}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_data_ready", {31'b0, mem_data_ready}, 32'd0);
    check("rst_ir_data_valid", {31'b0, ir_data_valid}, 32'd0);
    check("rst_dr_data_valid", {31'b0, dr_data_valid}, 32'd0);
    check("rst_ir_data", ir_data, 32'd0);
    check("rst_dr_data", dr_data, 32'd0);
    check("idle_no_req_ready", {30'b0, ir_addr_ready, dr_addr_ready}, 32'd0);

    // ir alone, zero-wait memory; response stalled 3 cycles while ir requests again
    ir_addr = 32'h100; ir_addr_valid = 1'b1;
    mem_addr_ready = 1'b1; mem_data_valid = 1'b1; mem_data = 32'h13;
    #1;
    check("ir_only_ready", {30'b0, ir_addr_ready, dr_addr_ready}, 32'd2);
    tick();  // N
    check("n1_mem_addr_valid", {31'b0, mem_addr_valid}, 32'd1);
    check("n1_mem_addr", mem_addr, 32'h100);
    check("n1_ir_ready_low", {31'b0, ir_addr_ready}, 32'd0);
    tick();
    check("n2_mem_data_ready", {31'b0, mem_data_ready}, 32'd1);
    check("n2_mem_addr_valid", {31'b0, mem_addr_valid}, 32'd0);
    tick();
    check("n3_ir_data_valid", {31'b0, ir_data_valid}, 32'd1);
    check("n3_ir_data", ir_data, 32'h13);
    check("n3_dr_data_valid", {31'b0, dr_data_valid}, 32'd0);
    mem_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ir_data_valid", {31'b0, ir_data_valid}, 32'd1);
      check("stall_ir_data", ir_data, 32'h13);
      check("stall_no_grant", {31'b0, ir_addr_ready}, 32'd0);
    end
    ir_addr_valid = 1'b0;
    ir_data_ready = 1'b1;
    tick();
    ir_data_ready = 1'b0;
    check("ir_done_valid", {31'b0, ir_data_valid}, 32'd0);
    check("ir_data_held", ir_data, 32'h13);

    // Simultaneous requests: last grant is ir
    ir_addr = 32'h100; dr_addr = 32'h2000;
    ir_addr_valid = 1'b1; dr_addr_valid = 1'b1;
`ifdef READ_ARB_ROUND_ROBIN_EN
    txn(1'b1, 32'h2000, 32'hA000_0001);
    txn(1'b0, 32'h100, 32'hA000_0002);
    last_dr = 1'b0;
`else
    txn(1'b1, 32'h2000, 32'hA000_0001);
    txn(1'b1, 32'h2000, 32'hA000_0002);
    dr_addr_valid = 1'b0;
    txn(1'b0, 32'h100, 32'hA000_0003);
    dr_addr_valid = 1'b1;
    last_dr = 1'b0;
`endif

    // Continuous contention for 20 transactions
    n_dr = 0;
    for (int i = 0; i < 20; i++) begin
`ifdef READ_ARB_ROUND_ROBIN_EN
      exp_dr = !last_dr;
`else
      exp_dr = 1'b1;
`endif
      #1;
      if (dr_addr_ready) n_dr++;
      txn(exp_dr, exp_dr ? 32'h2000 : 32'h100, 32'hB000_0000 + i);
      last_dr = exp_dr;
    end
`ifdef READ_ARB_ROUND_ROBIN_EN
    check("dr_grant_count", n_dr, 32'd10);
`else
    check("dr_grant_count", n_dr, 32'd20);
`endif
    ir_addr_valid = 1'b0; dr_addr_valid = 1'b0;
    tick();

    // Memory stalls address acceptance for 5 cycles
    dr_addr = 32'h2000; dr_addr_valid = 1'b1; mem_addr_ready = 1'b0;
    tick();
    dr_addr_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_mem_addr_valid", {31'b0, mem_addr_valid}, 32'd1);
      check("stall_mem_addr", mem_addr, 32'h2000);
      tick();
    end
    mem_addr_ready = 1'b1; mem_data = 32'h5555_AAAA;
    tick();
    check("post_stall_data_ready", {31'b0, mem_data_ready}, 32'd1);
    tick();
    check("post_stall_dr_data", dr_data, 32'h5555_AAAA);
    check("post_stall_dr_valid", {31'b0, dr_data_valid}, 32'd1);
    dr_data_ready = 1'b1;
    tick();
    dr_data_ready = 1'b0;

    // Reset while waiting for memory data
    ir_addr_valid = 1'b1; mem_data_valid = 1'b0;
    tick();
    ir_addr_valid = 1'b0;
    tick();
    check("pre_rst_data_ready", {31'b0, mem_data_ready}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_data_ready", {31'b0, mem_data_ready}, 32'd0);
    check("rst_async_mem_addr", mem_addr, 32'd0);
    check("rst_async_ir_data", ir_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mem_data_valid = 1'b1; mem_data = 32'h7777_7777;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abandon_data_valid", {30'b0, ir_data_valid, dr_data_valid}, 32'd0);
      check("abandon_data_ready", {31'b0, mem_data_ready}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/read_port_arbiter.md
READ_PORT_ARBITER -- requirements
Module: read_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: width of every address bus.
REQ-002 Parameter DATA_W, default 32: width of every data bus.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 ir_addr_valid  input  1  instruction requester address valid.
REQ-006 ir_addr  input  ADDR_W  instruction fetch address.
REQ-007 ir_addr_ready  output  1  instruction address accepted this cycle.
REQ-008 ir_data_valid  output  1  instruction read data valid.
REQ-009 ir_data  output  DATA_W  instruction read data.
REQ-010 ir_data_ready  input  1  instruction requester accepts data.
REQ-011 dr_addr_valid, dr_addr, dr_addr_ready, dr_data_valid, dr_data, dr_data_ready: data-read requester, same directions, widths and meanings as REQ-005..REQ-010.
REQ-012 mem_addr_valid  output  1  shared memory read address valid.
REQ-013 mem_addr  output  ADDR_W  shared memory read address.
REQ-014 mem_addr_ready  input  1  memory accepts address.
REQ-015 mem_data_valid  input  1  memory read data valid.
REQ-016 mem_data  input  DATA_W  memory read data.
REQ-017 mem_data_ready  output  1  arbiter accepts memory data.

Function
REQ-018 Transfer on any channel SHALL occur when valid and ready are both high at a rising edge.
REQ-019 FSM SHALL have states IDLE, ADDR, DATA, RESP; one outstanding memory transaction max.
REQ-020 IDLE: x_addr_ready SHALL be combinational, high only for the arbitration winner and only while its x_addr_valid is high; loser's ready SHALL be low.
REQ-021 IDLE with a winner: SHALL latch winner address and grant owner, go to ADDR next cycle.
REQ-022 ADDR: mem_addr_valid SHALL be 1, mem_addr SHALL equal the latched address (stable); on mem_addr_ready go to DATA.
REQ-023 DATA: mem_data_ready SHALL be 1; on mem_data_valid latch mem_data, go to RESP.
REQ-024 RESP: owner's x_data_valid SHALL be 1 with x_data = latched data; non-owner's x_data_valid SHALL be 0; on owner's x_data_ready go to IDLE.
REQ-025 mem_addr_valid, mem_data_ready, x_data_valid SHALL be registered (decoded from state only); all other requester ports SHALL be 0 outside the state listed.
REQ-026 Minimum latency: address accepted cycle N, mem_addr_valid cycle N+1, with zero-wait memory data latched N+2, x_data_valid cycle N+3.
REQ-027 Back-to-back: IDLE SHALL accept a new request the cycle after RESP completes; no lost or duplicated grants.
REQ-028 Requests arriving outside IDLE SHALL see ready=0 and SHALL be served later if still valid.
REQ-029 Arbitration policy: per Configuration; decision uses only current-cycle valids and the last-grant register.
REQ-030 x_data SHALL hold latched value after RESP until the next memory data latch.

Reset
REQ-031 rst low SHALL force state IDLE immediately (asynchronous), regardless of state.
REQ-032 Reset values: mem_addr_valid 0, mem_addr 0, mem_data_ready 0, ir/dr_data_valid 0, ir/dr_data 0, last-grant = instruction.
REQ-033 Reset mid-transaction SHALL abandon it; no response delivered afterwards.

Configuration
REQ-034 Macro READ_ARB_ROUND_ROBIN_EN defined: round-robin; on simultaneous valids, winner SHALL be the requester not granted last.
REQ-035 Macro undefined: fixed priority; dr SHALL always win over ir on simultaneous valids; last-grant register unused.

Verification
REQ-036 ir only, ir_addr=0x100, mem returns 0x00000013 zero-wait -> ir_data_valid at N+3 with 0x00000013, dr_data_valid stays 0.
REQ-037 ir and dr valid same cycle (ir 0x100, dr 0x2000), RR enabled, last-grant ir -> dr served first, then ir; RR disabled, repeated -> dr always first.
REQ-038 mem_addr_ready held low 5 cycles -> mem_addr_valid held high, mem_addr stable at 0x2000 all 5 cycles.
REQ-039 ir_data_ready low 3 cycles in RESP -> ir_data_valid and ir_data held, no new grant until accepted.
REQ-040 rst asserted during DATA -> outputs 0 immediately; later mem_data_valid ignored, no x_data_valid.
REQ-041 Continuous ir and dr valid for 20 transactions, RR enabled -> grants strictly alternate, 10 each.
